mdu: RTL
========

MDU -- requirements
Module: mdu

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 SHALL have port start, input, 1 bit: one-cycle pulse, launches the operation given on op.
REQ-004 SHALL have port op, input, 4 bits: MDU operation code (encoding in REQ-030).
REQ-005 SHALL have port A, input, 32 bits: operand rs (dividend/multiplicand; source for MTHI/MTLO).
REQ-006 SHALL have port B, input, 32 bits: operand rt (divisor/multiplier).
REQ-007 SHALL have port busy, output, 1 bit: high while a multiply/divide is in flight.
REQ-008 SHALL have port rd, output, 32 bits: read data for MFHI/MFLO.
REQ-009 SHALL have parameters MULT_CYCLES, default 5, busy length for MULT/MULTU; DIV_CYCLES, default 10, busy length for DIV/DIVU.

Function
REQ-010 SHALL hold 32-bit registers HI and LO, a pending-result pair (hi_p, lo_p) and a busy counter cnt.
REQ-011 SHALL start an operation when start=1, busy=0 and op is MULT/MULTU/DIV/DIVU: at that edge, compute into hi_p/lo_p and load cnt with MULT_CYCLES or DIV_CYCLES.
REQ-012 SHALL drive busy = (cnt != 0), registered; busy is high for exactly N cycles after the start cycle and low during the start cycle itself.
REQ-013 SHALL decrement cnt on each edge while cnt != 0; on the edge where cnt goes 1->0, it SHALL copy HI<=hi_p and LO<=lo_p.
REQ-014 SHALL make new HI/LO visible on rd in the first cycle with busy=0 after the operation.
REQ-015 MULT SHALL form the signed 64-bit product {HI,LO}; MULTU the unsigned one.
REQ-016 DIV SHALL give LO=signed quotient truncated toward zero and HI=remainder with the sign of the dividend; DIVU unsigned.
REQ-017 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-018 Divide by zero (B=0, DIV or DIVU) SHALL still assert busy for DIV_CYCLES and SHALL then leave HI and LO unchanged.
REQ-019 MTHI/MTLO with busy=0 SHALL write A into HI/LO at the edge; start is not required for these.
REQ-020 SHALL drive rd = HI when op=MFHI, LO when op=MFLO, else 0, combinationally, from the architectural HI/LO (not from hi_p/lo_p).
REQ-021 SHALL ignore start and MTHI/MTLO while busy=1; the operation in flight SHALL complete unaffected.
REQ-022 SHALL treat start with op NONE/MFHI/MFLO/MTHI/MTLO or an undefined code as no multiply/divide launch.

Reset
REQ-023 On reset=1 at an edge, SHALL clear HI, LO, hi_p, lo_p and cnt to 0; busy=0 from the next cycle.
REQ-024 Reset SHALL take priority over start, MTHI/MTLO and completion; a reset mid-operation SHALL abort it with no HI/LO update.
REQ-025 After reset, rd SHALL read 0 for MFHI and MFLO.

Structure
REQ-030 SHALL take op codes from a shared package: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8; the controller SHALL use the same package.
REQ-031 SHALL keep MULT_CYCLES/DIV_CYCLES defaults as package constants so the hazard unit can share them.
REQ-032 SHALL be one module with no sub-modules; the pipeline stalls its decode stage on (start | busy) with an MDU-using instruction in decode, which is outside this block.

Verification
REQ-040 Reset, then MULT A=0xFFFFFFFE(-2) B=3 -> busy high for cycles 1..5 after start; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-041 MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> after 5 busy cycles HI=0xFFFFFFFE, LO=0x00000001; MFHI/MFLO read them.
REQ-042 DIV A=-7 (0xFFFFFFF9) B=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU A=7 B=2 -> LO=3, HI=1.
REQ-043 MTHI 0x1234, MTLO 0x5678, then DIVU B=0 -> busy 10 cycles; HI=0x1234, LO=0x5678 unchanged.
REQ-044 MULT in flight, second start and MTLO 0xAAAA at busy cycle 2 -> both ignored; only the first result lands.
REQ-045 DIV started, reset at busy cycle 4 -> busy=0 next cycle, HI=LO=0, no later update.

Source files
------------

// File: rtl/mdu_pkg.sv
// MDU shared definitions: operation codes and default busy lengths,
// used by the MDU itself, the decode controller and the hazard unit.
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } mdu_op_e;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO registers. The result is computed in the
// launch cycle into a pending pair and only committed to HI/LO after a
// fixed busy period, mimicking a multi-cycle iterative unit.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] rd
);

  localparam int unsigned CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   hi_p_q, hi_p_d, lo_p_q, lo_p_d;
  logic [CW-1:0] cnt_q, cnt_d;

  mdu_op_e       op_e;
  logic [63:0]   prod_s, prod_u;
  logic signed [32:0] a_x, b_x;
  logic [31:0]   quo_s, rem_s, quo_u, rem_u;

  assign op_e = mdu_op_e'(op);
  assign busy = (cnt_q != '0);

  // Low 64 bits of a sign-extended product equal the signed product.
  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'b0, A} * {32'b0, B};

  // 33-bit signed divide so 0x80000000 / -1 yields +2^31, whose low word is 0x80000000.
  assign a_x   = {A[31], A};
  assign b_x   = {B[31], B};
  assign quo_s = 32'(a_x / b_x);
  assign rem_s = 32'(a_x % b_x);
  assign quo_u = A / B;
  assign rem_u = A % B;

  // Next-state: launch, countdown/commit, or MTHI/MTLO when idle.
  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    hi_p_d = hi_p_q;
    lo_p_d = lo_p_q;
    cnt_d  = cnt_q;
    if (busy) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        hi_d = hi_p_q;
        lo_d = lo_p_q;
      end
    end else begin
      if (start) begin
        unique case (op_e)
          OP_MULT: begin
            hi_p_d = prod_s[63:32];
            lo_p_d = prod_s[31:0];
            cnt_d  = CW'(MULT_CYCLES);
          end
          OP_MULTU: begin
            hi_p_d = prod_u[63:32];
            lo_p_d = prod_u[31:0];
            cnt_d  = CW'(MULT_CYCLES);
          end
          // Divide by zero parks the current HI/LO as the pending pair, so commit is a no-op.
          OP_DIV: begin
            hi_p_d = (B != '0) ? rem_s : hi_q;
            lo_p_d = (B != '0) ? quo_s : lo_q;
            cnt_d  = CW'(DIV_CYCLES);
          end
          OP_DIVU: begin
            hi_p_d = (B != '0) ? rem_u : hi_q;
            lo_p_d = (B != '0) ? quo_u : lo_q;
            cnt_d  = CW'(DIV_CYCLES);
          end
          default: ;
        endcase
      end
      if (op_e == OP_MTHI) hi_d = A;
      if (op_e == OP_MTLO) lo_d = A;
    end
  end

  // State registers with synchronous reset that aborts any operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      hi_p_q <= '0;
      lo_p_q <= '0;
      cnt_q  <= '0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      hi_p_q <= hi_p_d;
      lo_p_q <= lo_p_d;
      cnt_q  <= cnt_d;
    end
  end

  // Read port for MFHI/MFLO from the architectural registers.
  always_comb begin
    rd = '0;
    if (op_e == OP_MFHI) rd = hi_q;
    if (op_e == OP_MFLO) rd = lo_q;
  end

endmodule
